inference_sequencer: RTL and testbench
======================================

INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel word width (pass-through sizing only).
REQ-002 SHALL have parameter IMG_SIZE, default 224, input image side; pixels per frame = IMG_SIZE*IMG_SIZE.
REQ-003 SHALL have parameter FMAP_SIZE, default 112, first-layer output side.
REQ-004 SHALL have parameter CHANNELS, default 16, first-layer output channels; beats per frame = CHANNELS*FMAP_SIZE*FMAP_SIZE.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1000000, watchdog limit.
REQ-006 SHALL have ports: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-007 SHALL have ports: start in 1 frame request pulse; pixel_valid in 1 source has pixel; pixel_ready out 1 sequencer accepts pixel.
REQ-008 SHALL have ports: first_en out 1 first-layer enable; first_valid in 1 first-layer output beat; first_done in 1 first-layer finished.
REQ-009 SHALL have ports: tag_channel, tag_row, tag_col out 8 each, coordinate of current first_valid beat.
REQ-010 SHALL have ports: final_en out 1 final-layer enable; final_valid in 1 class scores ready.
REQ-011 SHALL have ports: busy out 1; done out 1 one-cycle pulse; error out 1 sticky; pixel_count out 32; beat_count out 32.

Function
REQ-012 SHALL implement states IDLE, STREAM, DRAIN, BACKEND, DONE, ERROR.
REQ-013 IDLE: start=1 SHALL clear pixel_count, beat_count, tags, error and enter STREAM next cycle; start in any other state SHALL be ignored.
REQ-014 STREAM: pixel_ready=1; first_en=pixel_valid; each pixel_valid cycle SHALL increment pixel_count; on accepting pixel IMG_SIZE*IMG_SIZE the FSM SHALL enter DRAIN.
REQ-015 DRAIN: pixel_ready=0, first_en=1; SHALL enter BACKEND on the first cycle where first_done=1 and beat_count equals CHANNELS*FMAP_SIZE*FMAP_SIZE (including a beat counted that same cycle).
REQ-016 BACKEND: final_en=1; final_valid=1 SHALL enter DONE.
REQ-017 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in STREAM, DRAIN, BACKEND only.
REQ-018 Every first_valid cycle in STREAM or DRAIN SHALL increment beat_count; first_valid in other states SHALL be ignored.
REQ-019 Tag order: tag_channel fastest (0..CHANNELS-1), then tag_col (0..FMAP_SIZE-1), then tag_row; tags are combinational from counters and advance after each first_valid.
REQ-020 After the last coordinate (C-1, F-1, F-1) tags SHALL wrap to (0,0,0); surplus beats still increment beat_count.
REQ-021 pixel_count and beat_count SHALL hold after frame end until next accepted start.
REQ-022 first_done before full beat_count SHALL NOT advance; beat_count reaching target without first_done SHALL NOT advance.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, all counters and tags 0, and pixel_ready, first_en, final_en, busy, done, error to 0, including mid-frame.
REQ-024 Reset release SHALL require a new start before any enable asserts.

Configuration
REQ-025 With SEQ_WATCHDOG_EN defined: a cycle counter SHALL reset on every first_valid, pixel accept, or state change; reaching TIMEOUT_CYCLES in STREAM, DRAIN or BACKEND SHALL enter ERROR.
REQ-026 ERROR: all enables 0, error=1, busy=0; start SHALL enter STREAM per REQ-013.
REQ-027 Without SEQ_WATCHDOG_EN: no watchdog logic; error tied 0; ERROR unreachable.

Structure
REQ-028 State enum and per-frame constants (pixel target, beat target) SHALL live in shared package mnv3_seq_pkg.
REQ-029 Coordinate counter SHALL be sub-module coord_tag_counter (channel/col/row cascade with wrap).

Verification (IMG_SIZE=8, FMAP_SIZE=4, CHANNELS=2, TIMEOUT_CYCLES=50)
REQ-030 Start, 64 continuous pixels -> pixel_count=64, DRAIN on cycle after 64th accept, pixel_ready falls.
REQ-031 32 first_valid beats -> tags sequence (0,0,0),(1,0,0),(0,0,1)...(1,3,3), then wrap to (0,0,0); beat_count=32.
REQ-032 first_done at beat 20, then remaining beats -> BACKEND only after beat 32; final_valid -> done pulse width 1, busy 0.
REQ-033 rst_n low at pixel 30 -> all outputs 0 immediately; start afterwards -> pixel_count restarts from 0.
REQ-034 SEQ_WATCHDOG_EN, stall in DRAIN 50 cycles -> error=1, first_en=0; start -> error clears, STREAM.
REQ-035 Start pulsed during BACKEND -> ignored, counts unchanged.

Source files
------------

// File: rtl/mnv3_seq_pkg.sv
// Shared types and per-frame constants for the inference sequencer.
package mnv3_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_BACKEND,
    ST_DONE,
    ST_ERROR
  } seq_state_e;

  localparam int DEF_IMG_SIZE  = 224;
  localparam int DEF_FMAP_SIZE = 112;
  localparam int DEF_CHANNELS  = 16;

  function automatic logic [31:0] pixel_target(input int img_size);
    return 32'(img_size * img_size);
  endfunction

  function automatic logic [31:0] beat_target(input int channels, input int fmap_size);
    return 32'(channels * fmap_size * fmap_size);
  endfunction

endpackage

// File: rtl/coord_tag_counter.sv
// Channel/col/row cascade counter that tags each first-layer output beat.
module coord_tag_counter #(
  parameter int CHANNELS  = 16,
  parameter int FMAP_SIZE = 112
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       advance_i,
  output logic [7:0] channel_o,
  output logic [7:0] row_o,
  output logic [7:0] col_o
);

  localparam logic [7:0] CH_LAST = 8'(CHANNELS - 1);
  localparam logic [7:0] FM_LAST = 8'(FMAP_SIZE - 1);

  logic [7:0] ch_q, row_q, col_q;

  // Channel runs fastest, then column, then row; the whole cascade wraps to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q  <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (clear_i) begin
      ch_q  <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (advance_i) begin
      if (ch_q == CH_LAST) begin
        ch_q <= '0;
        if (col_q == FM_LAST) begin
          col_q <= '0;
          row_q <= (row_q == FM_LAST) ? 8'd0 : row_q + 8'd1;
        end else begin
          col_q <= col_q + 8'd1;
        end
      end else begin
        ch_q <= ch_q + 8'd1;
      end
    end
  end

  assign channel_o = ch_q;
  assign row_o     = row_q;
  assign col_o     = col_q;

endmodule

// File: rtl/inference_sequencer.sv
// Frame sequencer: pixel stream -> first layer drain -> final layer -> done.
// Optional stall watchdog enabled by defining SEQ_WATCHDOG_EN.
module inference_sequencer
  import mnv3_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int IMG_SIZE       = DEF_IMG_SIZE,
  parameter int FMAP_SIZE      = DEF_FMAP_SIZE,
  parameter int CHANNELS       = DEF_CHANNELS,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        first_en,
  input  logic        first_valid,
  input  logic        first_done,
  output logic [7:0]  tag_channel,
  output logic [7:0]  tag_row,
  output logic [7:0]  tag_col,
  output logic        final_en,
  input  logic        final_valid,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] pixel_count,
  output logic [31:0] beat_count
);

  localparam logic [31:0] PIX_TGT  = pixel_target(IMG_SIZE);
  localparam logic [31:0] BEAT_TGT = beat_target(CHANNELS, FMAP_SIZE);

  // Tags are 8 bits wide, which bounds the feature-map geometry.
  if (DATA_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("DATA_WIDTH and TIMEOUT_CYCLES must be positive");
  end
  if (CHANNELS < 1 || CHANNELS > 256 || FMAP_SIZE < 1 || FMAP_SIZE > 256) begin : g_bad_geom
    $error("CHANNELS and FMAP_SIZE must be within 1..256");
  end

  seq_state_e  state_q, state_d, state_base;
  logic [31:0] pix_cnt_q, pix_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic        pixel_ready_q, final_en_q, busy_q, done_q, error_q;
  logic        in_stream, in_drain, pix_acc, beat_acc, frame_start, wd_expired;

  assign in_stream   = (state_q == ST_STREAM);
  assign in_drain    = (state_q == ST_DRAIN);
  assign pix_acc     = in_stream & pixel_valid;
  assign beat_acc    = (in_stream | in_drain) & first_valid;
  assign frame_start = start & ((state_q == ST_IDLE) | (state_q == ST_ERROR));

  always_comb begin
    state_base = state_q;
    pix_cnt_d  = pix_cnt_q + {31'd0, pix_acc};
    beat_cnt_d = beat_cnt_q + {31'd0, beat_acc};
    if (frame_start) begin
      pix_cnt_d  = '0;
      beat_cnt_d = '0;
    end
    case (state_q)
      ST_IDLE, ST_ERROR: if (start) state_base = ST_STREAM;
      ST_STREAM:  if (pix_acc && pix_cnt_d == PIX_TGT) state_base = ST_DRAIN;
      // The beat arriving this very cycle counts toward the drain target.
      ST_DRAIN:   if (first_done && beat_cnt_d == BEAT_TGT) state_base = ST_BACKEND;
      ST_BACKEND: if (final_valid) state_base = ST_DONE;
      ST_DONE:    state_base = ST_IDLE;
      default:    state_base = ST_IDLE;
    endcase
    state_d = wd_expired ? ST_ERROR : state_base;
  end

`ifdef SEQ_WATCHDOG_EN
  logic [31:0] wd_q;
  logic        wd_active, wd_kick;

  assign wd_active  = in_stream | in_drain | (state_q == ST_BACKEND);
  assign wd_kick    = first_valid | pix_acc | (state_base != state_q);
  assign wd_expired = wd_active & ~wd_kick & (wd_q >= 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (!wd_active || wd_kick) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 32'd1;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Status outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pix_cnt_q     <= '0;
      beat_cnt_q    <= '0;
      pixel_ready_q <= 1'b0;
      final_en_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      pixel_ready_q <= (state_d == ST_STREAM);
      final_en_q    <= (state_d == ST_BACKEND);
      busy_q        <= (state_d == ST_STREAM) | (state_d == ST_DRAIN) | (state_d == ST_BACKEND);
      done_q        <= (state_d == ST_DONE);
      error_q       <= (state_d == ST_ERROR);
    end
  end

  coord_tag_counter #(
    .CHANNELS  (CHANNELS),
    .FMAP_SIZE (FMAP_SIZE)
  ) u_tags (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (frame_start),
    .advance_i (beat_acc),
    .channel_o (tag_channel),
    .row_o     (tag_row),
    .col_o     (tag_col)
  );

  assign first_en    = pix_acc | in_drain;
  assign pixel_ready = pixel_ready_q;
  assign final_en    = final_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign pixel_count = pix_cnt_q;
  assign beat_count  = beat_cnt_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Randomized scoreboard bench for inference_sequencer (small geometry).
module tb_inference_sequencer;

  localparam int IMG   = 8;
  localparam int FM    = 4;
  localparam int CH    = 2;
  localparam int TO    = 50;
  localparam int NPIX  = IMG * IMG;
  localparam int NBEAT = CH * FM * FM;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, pixel_valid = 1'b0, first_valid = 1'b0;
  logic        first_done = 1'b0, final_valid = 1'b0;
  logic        pixel_ready, first_en, final_en, busy, done, error;
  logic [7:0]  tag_channel, tag_row, tag_col;
  logic [31:0] pixel_count, beat_count;

  inference_sequencer #(
    .DATA_WIDTH(16), .IMG_SIZE(IMG), .FMAP_SIZE(FM), .CHANNELS(CH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .first_en(first_en), .first_valid(first_valid),
    .first_done(first_done), .tag_channel(tag_channel), .tag_row(tag_row),
    .tag_col(tag_col), .final_en(final_en), .final_valid(final_valid),
    .busy(busy), .done(done), .error(error),
    .pixel_count(pixel_count), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int row; int col; } tag_t;
  typedef struct { int pix; int beat; } frame_t;

  tag_t   tag_q[$];
  frame_t frame_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     mon_en = 1'b0;
  logic   done_prev = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference coordinate for the n-th beat of a frame.
  function automatic tag_t ref_tag(input int n);
    tag_t t;
    t.ch  = n % CH;
    t.col = (n / CH) % FM;
    t.row = (n / (CH * FM)) % FM;
    return t;
  endfunction

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (first_valid && busy && !final_en) begin
        if (tag_q.size() == 0) begin
          check("tag_queue_nonempty", tag_q.size(), 1);
        end else begin
          tag_t e;
          e = tag_q.pop_front();
          check("tag_channel", tag_channel, e.ch);
          check("tag_col", tag_col, e.col);
          check("tag_row", tag_row, e.row);
        end
      end
      if (done) begin
        if (done_prev) check("done_width", 2, 1);
        if (frame_q.size() == 0) begin
          check("frame_queue_nonempty", frame_q.size(), 1);
        end else begin
          frame_t f;
          f = frame_q.pop_front();
          check("done_pixel_count", pixel_count, f.pix);
          check("done_beat_count", beat_count, f.beat);
          check("done_busy", busy, 0);
          check("done_tag_wrap", {tag_channel, tag_row, tag_col}, 0);
        end
      end
      done_prev = done;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_frame(input int done_at, input bit start_in_backend);
    int pix, beats, cyc;
    bit seen;
    frame_t f;
    f.pix = NPIX; f.beat = NBEAT;
    frame_q.push_back(f);
    pulse_start();
    check("stream_pixel_ready", pixel_ready, 1);
    check("stream_pixel_count_clear", pixel_count, 0);
    pix = 0; beats = 0; cyc = 0;
    while ((pix < NPIX || beats < NBEAT) && cyc < 2000) begin
      pixel_valid = (pix < NPIX) && ($urandom_range(0, 3) != 0);
      first_valid = (beats < NBEAT) && ($urandom_range(0, 2) != 0);
      first_done  = (beats >= done_at);
      if (first_valid) begin
        tag_q.push_back(ref_tag(beats));
        beats++;
      end
      if (pixel_valid) pix++;
      @(posedge clk); #1;
      if (pixel_valid && pix == NPIX) begin
        check("pixel_ready_fall", pixel_ready, 0);
        check("pixel_count_full", pixel_count, NPIX);
      end
      if (first_done && beats < NBEAT) check("early_backend", final_en, 0);
      cyc++;
    end
    if (cyc >= 2000) check("stream_budget", cyc, 0);
    pixel_valid = 1'b0;
    first_valid = 1'b0;
    first_done  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (final_en) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("final_en_seen", seen, 1);
    check("backend_beat_count", beat_count, NBEAT);
    if (start_in_backend) begin
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("start_ignored_final_en", final_en, 1);
      check("start_ignored_pixel_count", pixel_count, NPIX);
      check("start_ignored_beat_count", beat_count, NBEAT);
    end
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1 final_valid = 1'b1;
    @(posedge clk); #1 final_valid = 1'b0;
    first_done = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("hold_pixel_count", pixel_count, NPIX);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=1 required=0");
    $fatal(1, "simulation timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {pixel_ready, first_en, final_en, busy, done, error}, 0);
    check("rst_counts", pixel_count | beat_count, 0);
    check("rst_tags", {tag_channel, tag_row, tag_col}, 0);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("no_start_pixel_ready", pixel_ready, 0);
    end
    mon_en = 1'b1;

    run_frame(20, 1'b0);
    run_frame(NBEAT, 1'b1);
    for (int k = 0; k < 3; k++) run_frame($urandom_range(0, NBEAT), 1'($urandom_range(0, 1)));

    // Reset in the middle of a frame.
    pulse_start();
    pixel_valid = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("mid_pixel_count", pixel_count, 30);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {pixel_ready, first_en, final_en, busy, done, error}, 0);
    check("async_rst_pixel_count", pixel_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("post_rst_first_en", first_en, 0);
      check("post_rst_pixel_count", pixel_count, 0);
    end
    pixel_valid = 1'b0;
    tag_q.delete();
    done_prev = 1'b0;
    mon_en = 1'b1;
    run_frame($urandom_range(0, NBEAT), 1'b0);

`ifdef SEQ_WATCHDOG_EN
    begin
      bit hit;
      pulse_start();
      pixel_valid = 1'b1;
      repeat (NPIX) @(posedge clk);
      #1 pixel_valid = 1'b0;
      check("wd_in_drain", first_en, 1);
      hit = 1'b0;
      for (int i = 0; i < 3 * TO && !hit; i++) begin
        @(posedge clk); #1;
        if (error) hit = 1'b1;
      end
      check("wd_error", hit, 1);
      check("wd_first_en", first_en, 0);
      check("wd_busy", busy, 0);
      pulse_start();
      check("wd_error_clear", error, 0);
      check("wd_restream", pixel_ready, 1);
      mon_en = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      mon_en = 1'b1;
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    check("tag_queue_drained", tag_q.size(), 0);
    check("frame_queue_drained", frame_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
